// File: rtl/npu_acc_pkg.sv
// ---------------------------------------------------------------------------
// npu_acc_pkg
// Shared definitions for the compressor-row accumulator:
//   - default widths for the row vectors, accumulator and beat counter
//   - accumulator FSM state encoding
// ---------------------------------------------------------------------------
package npu_acc_pkg;

    localparam int IN_W_DEF  = 8;   // width of each compressor output row
    localparam int ACC_W_DEF = 20;  // accumulator / result width
    localparam int CNT_W_DEF = 8;   // beat counter width

    // IDLE: no group open, ACC: group open, HOLD: result presented
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } acc_state_e;

endpackage

// File: rtl/adder_tree_acc_if.sv
// ---------------------------------------------------------------------------
// adder_tree_acc_if
// Beat input channel and group result channel of adder_tree_acc.
//   master : beat producer / result consumer (drives in_*, out_ready)
//   slave  : the accumulator (drives in_ready, out_*)
// Signals:
//   in_valid/in_ready          beat handshake
//   in_sum/in_carry/in_cout    compressor rows, weights 1/2/4
//   in_last                    final beat of a group
//   out_valid/out_ready        result handshake
//   out_data/out_cnt/out_ovf   group sum, beat count, overflow flag
// ---------------------------------------------------------------------------
interface adder_tree_acc_if
    import npu_acc_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_sum;
    logic [IN_W-1:0]  in_carry;
    logic [IN_W-1:0]  in_cout;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;

    modport master (
        output in_valid, in_sum, in_carry, in_cout, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_cnt, out_ovf
    );

    modport slave (
        input  in_valid, in_sum, in_carry, in_cout, in_last, out_ready,
        output in_ready, out_valid, out_data, out_cnt, out_ovf
    );

endinterface

// File: rtl/adder_tree_acc_row_cpa.sv
// ---------------------------------------------------------------------------
// row_cpa
// Combinational carry-propagate adder that collapses the three compressor
// rows into one beat value: sum_row + 2*carry_row + 4*cout_row.
// The result is IN_W+3 bits wide, so it can never truncate.
// Ports:
//   sum_row, carry_row, cout_row  IN_W-bit rows (weights 1, 2, 4)
//   value                         IN_W+3-bit unsigned beat value
// ---------------------------------------------------------------------------
module row_cpa
    import npu_acc_pkg::*;
#(
    parameter int IN_W = IN_W_DEF
) (
    input  logic [IN_W-1:0] sum_row,
    input  logic [IN_W-1:0] carry_row,
    input  logic [IN_W-1:0] cout_row,
    output logic [IN_W+2:0] value
);

    always_comb begin
        value = {3'b000, sum_row} + {2'b00, carry_row, 1'b0} + {1'b0, cout_row, 2'b00};
    end

endmodule

// File: rtl/adder_tree_acc.sv
// ---------------------------------------------------------------------------
// adder_tree_acc
// Two-stage accumulator for compressor-tree output rows. Stage 1 registers
// the weighted beat value of every accepted beat; stage 2 adds it into the
// group accumulator. A beat flagged last closes the group and the result is
// held on the out_* channel until consumed.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    adder_tree_acc_if.slave (beat input + result output)
// Build option:
//   ADDER_TREE_ACC_SAT_EN  defined: accumulator clamps to all-ones on
//                          overflow and stays there for the rest of the
//                          group; undefined: accumulator wraps.
//                          out_ovf behaves the same either way.
// ---------------------------------------------------------------------------
module adder_tree_acc
    import npu_acc_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    adder_tree_acc_if.slave   bus
);

    localparam int VW = IN_W + 3;   // beat value width

    logic [VW-1:0]    beat_value;
    logic             in_ready;
    logic             accept;

    acc_state_e       state_q,   state_d;
    logic             s1_v_q,    s1_v_d;
    logic             s1_last_q, s1_last_d;
    logic [VW-1:0]    s1_val_q,  s1_val_d;
    logic [ACC_W-1:0] acc_q,     acc_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             ovf_q,     ovf_d;

    logic [ACC_W-1:0] acc_base;
    logic [CNT_W-1:0] cnt_base;
    logic             ovf_base;
    logic [ACC_W:0]   step_sum;   // one extra bit catches the carry-out

    row_cpa #(.IN_W(IN_W)) u_row_cpa (
        .sum_row   (bus.in_sum),
        .carry_row (bus.in_carry),
        .cout_row  (bus.in_cout),
        .value     (beat_value)
    );

    // Stop accepting once a last beat is in flight, so the closing beat is
    // never followed by a beat that would land in the held result.
    assign in_ready      = (state_q != ST_HOLD) && !(s1_v_q && s1_last_q);
    assign accept        = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_data  = acc_q;
    assign bus.out_cnt   = cnt_q;
    assign bus.out_ovf   = ovf_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        s1_v_d    = accept;
        s1_last_d = s1_last_q;
        s1_val_d  = s1_val_q;
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;

        // Stage-1 payload only moves on an accepted beat; idle input data is
        // don't-care and never reaches the accumulator.
        if (accept) begin
            s1_last_d = bus.in_last;
            s1_val_d  = beat_value;
        end

        // In IDLE the incoming beat opens a new group: start from zero.
        acc_base = (state_q == ST_IDLE) ? '0   : acc_q;
        cnt_base = (state_q == ST_IDLE) ? '0   : cnt_q;
        ovf_base = (state_q == ST_IDLE) ? 1'b0 : ovf_q;
        step_sum = {1'b0, acc_base} + {{(ACC_W + 1 - VW){1'b0}}, s1_val_q};

        case (state_q)
            ST_IDLE, ST_ACC: begin
                if (s1_v_q) begin
                    ovf_d = ovf_base | step_sum[ACC_W];
`ifdef ADDER_TREE_ACC_SAT_EN
                    acc_d = (ovf_base || step_sum[ACC_W]) ? '1 : step_sum[ACC_W-1:0];
`else
                    acc_d = step_sum[ACC_W-1:0];
`endif
                    cnt_d   = (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);
                    state_d = s1_last_q ? ST_HOLD : ST_ACC;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            s1_v_q    <= 1'b0;
            s1_last_q <= 1'b0;
            s1_val_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_v_q    <= s1_v_d;
            s1_last_q <= s1_last_d;
            s1_val_q  <= s1_val_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_adder_tree_acc.sv
// ---------------------------------------------------------------------------
// tb_adder_tree_acc
// Two instances share one stimulus stream: A (IN_W=8, ACC_W=20, CNT_W=8) and
// B (IN_W=8, ACC_W=12, CNT_W=3), so B exercises overflow and counter
// saturation. The reference model keeps the exact group sum as a plain
// integer and derives each expected result from it; expected results are
// queued when the last beat is accepted and popped by a monitor on every
// result handshake.
// ---------------------------------------------------------------------------
module tb_adder_tree_acc;

    typedef struct {
        longint data;
        longint cnt;
        bit     ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_sum = '0;
    logic [7:0] in_carry = '0;
    logic [7:0] in_cout = '0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;

    int total = 0;
    int bad = 0;
    int rmode = 0;            // 0: out_ready driven by hand, 1: high, 2: random

    exp_t   q0[$];
    exp_t   q1[$];
    longint grp_sum = 0;
    int     grp_beats = 0;

    adder_tree_acc_if #(.IN_W(8), .ACC_W(20), .CNT_W(8)) bus_a ();
    adder_tree_acc_if #(.IN_W(8), .ACC_W(12), .CNT_W(3)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_sum    = in_sum;
    assign bus_a.in_carry  = in_carry;
    assign bus_a.in_cout   = in_cout;
    assign bus_a.in_last   = in_last;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_sum    = in_sum;
    assign bus_b.in_carry  = in_carry;
    assign bus_b.in_cout   = in_cout;
    assign bus_b.in_last   = in_last;
    assign bus_b.out_ready = out_ready;

    adder_tree_acc #(.IN_W(8), .ACC_W(20), .CNT_W(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    adder_tree_acc #(.IN_W(8), .ACC_W(12), .CNT_W(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // flattened view of both result channels for the shared monitor
    logic [1:0]  ov;
    logic [1:0]  oo;
    logic [1:0]  ir;
    logic [63:0] od [2];
    logic [63:0] oc [2];

    assign ov[0] = bus_a.out_valid;
    assign ov[1] = bus_b.out_valid;
    assign oo[0] = bus_a.out_ovf;
    assign oo[1] = bus_b.out_ovf;
    assign ir[0] = bus_a.in_ready;
    assign ir[1] = bus_b.in_ready;
    assign od[0] = 64'(bus_a.out_data);
    assign od[1] = 64'(bus_b.out_data);
    assign oc[0] = 64'(bus_a.out_cnt);
    assign oc[1] = 64'(bus_b.out_cnt);

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic exp_t model_result(input longint exact, input int beats, input int accw, input int cntw);
        exp_t   e;
        longint lim;
        longint cmax;
        lim   = longint'(1) << accw;
        cmax  = (longint'(1) << cntw) - 1;
        e.ovf = (exact >= lim);
`ifdef ADDER_TREE_ACC_SAT_EN
        e.data = e.ovf ? lim - 1 : exact;
`else
        e.data = exact % lim;
`endif
        e.cnt = (longint'(beats) > cmax) ? cmax : longint'(beats);
        return e;
    endfunction

    task automatic model_accept(input logic [7:0] s, input logic [7:0] c, input logic [7:0] co, input bit last);
        grp_sum   += longint'(s) + 2 * longint'(c) + 4 * longint'(co);
        grp_beats += 1;
        if (last) begin
            q0.push_back(model_result(grp_sum, grp_beats, 20, 8));
            q1.push_back(model_result(grp_sum, grp_beats, 12, 3));
            grp_sum   = 0;
            grp_beats = 0;
        end
    endtask

    // Present one beat and hold it until the DUT takes it.
    task automatic send_beat(input logic [7:0] s, input logic [7:0] c, input logic [7:0] co, input bit last);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_sum   = s;
        in_carry = c;
        in_cout  = co;
        in_last  = last;
        while (!ir[0] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!ir[0]) begin
            check("in_ready_timeout", 64'(ir[0]), 64'd1);
            in_valid = 1'b0;
            return;
        end
        check("in_ready_match", 64'(ir[1]), 64'(ir[0]));
        model_accept(s, c, co, last);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sum   = 8'($urandom);
        in_carry = 8'($urandom);
        in_cout  = 8'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic wait_out_valid(input int k);
        int n = 0;
        while (!ov[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ov[k]) check($sformatf("out_valid_timeout_%0d", k), 64'(ov[k]), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_q0_left", 64'(q0.size()), 64'd0);
        check("drain_q1_left", 64'(q1.size()), 64'd0);
    endtask

    task automatic check_reset_state(input int k);
        check($sformatf("rst_out_valid_%0d", k), 64'(ov[k]), 64'd0);
        check($sformatf("rst_out_data_%0d", k), od[k], 64'd0);
        check($sformatf("rst_out_cnt_%0d", k), oc[k], 64'd0);
        check($sformatf("rst_out_ovf_%0d", k), 64'(oo[k]), 64'd0);
        check($sformatf("rst_in_ready_%0d", k), 64'(ir[k]), 64'd1);
    endtask

    // Samples 1 ns before each rising edge: compares on every result
    // handshake and checks that a held, unconsumed result does not move.
    task automatic run_monitor(input int k);
        logic        pv = 1'b0;
        logic        ph = 1'b0;
        logic        po = 1'b0;
        logic [63:0] pd = '0;
        logic [63:0] pc = '0;
        exp_t        e;
        string       t;
        t = (k == 0) ? "a" : "b";
        forever begin
            @(negedge clk);
            #4;
            if (reset) begin
                pv = 1'b0;
                ph = 1'b0;
                continue;
            end
            if (pv && !ph) begin
                check({t, "_hold_valid"}, 64'(ov[k]), 64'd1);
                check({t, "_hold_data"}, od[k], pd);
                check({t, "_hold_cnt"}, oc[k], pc);
                check({t, "_hold_ovf"}, 64'(oo[k]), 64'(po));
            end
            ph = ov[k] && out_ready;
            if (ph) begin
                if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                    total++;
                    bad++;
                    $display("FAIL %s_unexpected_result: got data=%0d with nothing expected at %0t", t, od[k], $time);
                end else begin
                    if (k == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    check({t, "_sb_data"}, od[k], 64'(e.data));
                    check({t, "_sb_cnt"}, oc[k], 64'(e.cnt));
                    check({t, "_sb_ovf"}, 64'(oo[k]), 64'(e.ovf));
                end
            end
            pv = ov[k];
            pd = od[k];
            pc = oc[k];
            po = oo[k];
        end
    endtask

    initial run_monitor(0);
    initial run_monitor(1);

    initial forever begin
        @(negedge clk);
        if (rmode == 1)      out_ready = 1'b1;
        else if (rmode == 2) out_ready = ($urandom_range(0, 1) == 1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        @(negedge clk);
        #1;
        check_reset_state(0);
        check_reset_state(1);
        @(negedge clk);
        reset = 1'b0;

        // single beat 1/1/1 -> 7, valid two edges after the accept cycle
        rmode = 1;
        send_beat(8'h01, 8'h01, 8'h01, 1'b1);
        check("lat_valid_early", 64'(ov[0]), 64'd0);
        check("lat_in_ready_last_inflight", 64'(ir[0]), 64'd0);
        @(posedge clk);
        #1;
        check("lat_valid", 64'(ov[0]), 64'd1);
        check("single_data", od[0], 64'd7);
        check("single_cnt", oc[0], 64'd1);
        check("single_ovf", 64'(oo[0]), 64'd0);
        drain();

        // four full beats -> 7140; hold with out_ready low, beat offered in HOLD
        rmode = 0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(8'hFF, 8'hFF, 8'hFF, i == 3);
        wait_out_valid(0);
        check("four_data", od[0], 64'd7140);
        check("four_cnt", oc[0], 64'd4);
        check("four_ovf", 64'(oo[0]), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sum   = 8'd100;
            in_carry = 8'd0;
            in_cout  = 8'd0;
            in_last  = 1'b1;
            #1;
            check("hold_in_ready", 64'(ir[0]), 64'd0);
            check("hold_data_7140", od[0], 64'd7140);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid", 64'(ov[0]), 64'd0);
        check("release_in_ready", 64'(ir[0]), 64'd1);
        rmode = 1;
        send_beat(8'd5, 8'd0, 8'd0, 1'b1);
        wait_out_valid(0);
        check("after_hold_data", od[0], 64'd5);
        check("after_hold_cnt", oc[0], 64'd1);
        drain();

        // ACC_W=12: three beats of 1785
        rmode = 0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(8'hFF, 8'hFF, 8'hFF, i == 2);
        wait_out_valid(1);
`ifdef ADDER_TREE_ACC_SAT_EN
        check("narrow_data", od[1], 64'd4095);
`else
        check("narrow_data", od[1], 64'd1259);
`endif
        check("narrow_ovf", 64'(oo[1]), 64'd1);
        check("narrow_cnt", oc[1], 64'd3);
        rmode = 1;
        drain();

        // reset in the middle of a group
        send_beat(8'h10, 8'h00, 8'h00, 1'b0);
        send_beat(8'h20, 8'h01, 8'h00, 1'b0);
        @(negedge clk);
        reset     = 1'b1;
        grp_sum   = 0;
        grp_beats = 0;
        #1;
        check_reset_state(0);
        check_reset_state(1);
        @(negedge clk);
        reset = 1'b0;
        send_beat(8'd3, 8'd0, 8'd0, 1'b1);
        wait_out_valid(0);
        check("post_reset_data", od[0], 64'd3);
        check("post_reset_cnt", oc[0], 64'd1);
        drain();

        // randomized groups with random back-pressure
        rmode = 2;
        for (int g = 0; g < 40; g++) begin
            int nb;
            nb = $urandom_range(1, 10);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 3) == 0)
                    send_beat(8'hFF, 8'hFF, 8'hFF, b == nb - 1);
                else
                    send_beat(8'($urandom), 8'($urandom), 8'($urandom), b == nb - 1);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        rmode = 1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
